// File: rtl/frame_store_ctrl_pkg.sv
// Shared state encodings for the frame-store controller.
package frame_store_ctrl_pkg;

    // Top-level BRAM usage mode, exported on bram_state for pixel selection downstream.
    typedef enum logic [1:0] {
        BRAM_IDLE     = 2'b00,
        CAPTURE_FRAME = 2'b01,
        WRITING_FRAME = 2'b10,
        READING_FRAME = 2'b11
    } bram_state_e;

endpackage

// File: rtl/frame_store_ctrl_pixel_addr_counter.sv
// Pixel address counter: synchronous clear, increment, saturates at LAST.
module pixel_addr_counter #(
    parameter int                ADDR_W = 18,
    parameter logic [ADDR_W-1:0] LAST   = '1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Clear has priority; increment stops at LAST so the address never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !last_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/frame_store_ctrl.sv
// Frame-store controller: captures one frame into a single-port BRAM, then
// serves it to VGA readback and to a byte-at-a-time PC transfer (PC wins the port).
module frame_store_ctrl
    import frame_store_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 400,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              store_req,
    input  logic              release_req,
    input  logic              pc_send_req,
    input  logic              pc_ack,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              blank,
    input  logic              vsync,
    output logic [1:0]        bram_state,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              in_display_bram,
    output logic              pc_byte_valid,
    output logic              pc_done
);

    // PC transfer sub-states: address phase, one BRAM latency cycle, byte held until ack.
    typedef enum logic [1:0] {
        PC_IDLE  = 2'b00,
        PC_ADDR  = 2'b01,
        PC_WAIT  = 2'b10,
        PC_VALID = 2'b11
    } pc_state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);

    bram_state_e state_q, state_d;
    pc_state_e   pc_q, pc_d;
    logic        vsync_q, fs_q;
    logic        disp_q, disp_d;
    logic        pc_done_q, pc_done_d;

    logic              wr_clr, wr_inc, wr_last;
    logic              rd_clr, rd_inc, rd_last;
    logic              pc_clr, pc_inc, pc_last;
    logic [ADDR_W-1:0] wr_addr, rd_addr, pc_addr;

    logic win;
    logic pc_busy;

    assign win     = !blank && (hcount < H_LIM) && (vcount < V_LIM);
    assign pc_busy = (pc_q != PC_IDLE);

    pixel_addr_counter #(.ADDR_W(ADDR_W), .LAST(LAST_ADDR)) u_wr_cnt (
        .clk(clk), .reset_n(reset_n), .clr_i(wr_clr), .inc_i(wr_inc),
        .cnt_o(wr_addr), .last_o(wr_last)
    );

    pixel_addr_counter #(.ADDR_W(ADDR_W), .LAST(LAST_ADDR)) u_rd_cnt (
        .clk(clk), .reset_n(reset_n), .clr_i(rd_clr), .inc_i(rd_inc),
        .cnt_o(rd_addr), .last_o(rd_last)
    );

    pixel_addr_counter #(.ADDR_W(ADDR_W), .LAST(LAST_ADDR)) u_pc_cnt (
        .clk(clk), .reset_n(reset_n), .clr_i(pc_clr), .inc_i(pc_inc),
        .cnt_o(pc_addr), .last_o(pc_last)
    );

    // Frame start strobe: registered rising edge of vsync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            fs_q    <= vsync & ~vsync_q;
        end
    end

    // Mode and PC sub-FSM registers, plus the one-cycle-late display-valid and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BRAM_IDLE;
            pc_q      <= PC_IDLE;
            disp_q    <= 1'b0;
            pc_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            disp_q    <= disp_d;
            pc_done_q <= pc_done_d;
        end
    end

    // Next-state and counter control; release beats store, store only recaptures when PC is idle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_done_d = 1'b0;
        wr_clr    = 1'b0;
        wr_inc    = 1'b0;
        rd_clr    = 1'b0;
        rd_inc    = 1'b0;
        pc_clr    = 1'b0;
        pc_inc    = 1'b0;
        disp_d    = (state_q == READING_FRAME) && win;
        case (state_q)
            BRAM_IDLE: begin
                if (store_req) state_d = CAPTURE_FRAME;
            end
            CAPTURE_FRAME: begin
                if (release_req) begin
                    state_d = BRAM_IDLE;
                end else if (fs_q) begin
                    state_d = WRITING_FRAME;
                    wr_clr  = 1'b1;
                end
            end
            WRITING_FRAME: begin
                if (release_req) begin
                    state_d = BRAM_IDLE;
                end else if (win) begin
                    wr_inc = 1'b1;
                    if (wr_last) begin
                        state_d = READING_FRAME;
                        rd_clr  = 1'b1;
                    end
                end
            end
            READING_FRAME: begin
                if (release_req) begin
                    state_d = BRAM_IDLE;
                    pc_d    = PC_IDLE;
                end else if (store_req && !pc_busy) begin
                    state_d = CAPTURE_FRAME;
                end else begin
                    // Display address keeps tracking the raster even while PC owns the port.
                    if (fs_q)     rd_clr = 1'b1;
                    else if (win) rd_inc = 1'b1;
                    case (pc_q)
                        PC_IDLE: begin
                            if (pc_send_req) begin
                                pc_d   = PC_ADDR;
                                pc_clr = 1'b1;
                            end
                        end
                        PC_ADDR:  pc_d = PC_WAIT;
                        PC_WAIT:  pc_d = PC_VALID;
                        PC_VALID: begin
                            if (pc_ack) begin
                                if (pc_last) begin
                                    pc_d      = PC_IDLE;
                                    pc_done_d = 1'b1;
                                end else begin
                                    pc_inc = 1'b1;
                                    pc_d   = PC_ADDR;
                                end
                            end
                        end
                        default: pc_d = PC_IDLE;
                    endcase
                end
            end
            default: state_d = BRAM_IDLE;
        endcase
    end

    // BRAM port steering: writer while capturing, otherwise PC reader over display reader.
    always_comb begin
        bram_we   = 1'b0;
        bram_addr = '0;
        case (state_q)
            WRITING_FRAME: begin
                bram_we   = win;
                bram_addr = wr_addr;
            end
            READING_FRAME: begin
                bram_addr = pc_busy ? pc_addr : rd_addr;
            end
            default: ;
        endcase
    end

    assign bram_state      = state_q;
    assign in_display_bram = disp_q && (state_q == READING_FRAME) && !pc_busy;
    assign pc_byte_valid   = (state_q == READING_FRAME) && (pc_q == PC_VALID);
    assign pc_done         = pc_done_q;

    // rd_last is not needed: the display reader is re-cleared every frame start.
    logic unused_rd_last;
    assign unused_rd_last = rd_last;

endmodule

// File: tb/tb_frame_store_ctrl.sv
// Bench for frame_store_ctrl on a tiny 8x4 raster (12x7 total timing).
module tb_frame_store_ctrl;

    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int AW    = 5;
    localparam int LAST  = 31;
    localparam int H_TOT = 12;
    localparam int V_TOT = 7;

    logic          clk = 1'b0;
    logic          reset_n, store_req, release_req, pc_send_req, pc_ack;
    logic [10:0]   hcount;
    logic [9:0]    vcount;
    logic          blank, vsync;
    logic [1:0]    bram_state;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic          in_display_bram, pc_byte_valid, pc_done;

    int n_checks = 0;
    int n_fail   = 0;

    int h, v;
    bit rnd_blank, xb;

    // Reference model: mode 0..3, write/read/pc indices, pc phase 0 idle 1 addr 2 wait 3 valid.
    int m_state, m_wr, m_rd, m_pc, m_ph;
    bit m_disp_prev, m_done, vs_d1, vs_d2;

    always #5 clk = ~clk;

    frame_store_ctrl #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .store_req(store_req), .release_req(release_req),
        .pc_send_req(pc_send_req), .pc_ack(pc_ack), .hcount(hcount), .vcount(vcount),
        .blank(blank), .vsync(vsync), .bram_state(bram_state), .bram_we(bram_we),
        .bram_addr(bram_addr), .in_display_bram(in_display_bram),
        .pc_byte_valid(pc_byte_valid), .pc_done(pc_done)
    );

    function automatic bit tb_win();
        return (h < H_ACT) && (v < V_ACT) && !xb;
    endfunction

    function automatic bit exp_we();
        return (m_state == 2) && tb_win();
    endfunction

    function automatic int exp_addr();
        if (m_state == 2) return m_wr;
        if (m_state == 3) return (m_ph != 0) ? m_pc : m_rd;
        return 0;
    endfunction

    function automatic bit exp_disp();
        return m_disp_prev && (m_state == 3) && (m_ph == 0);
    endfunction

    function automatic bit exp_pcv();
        return (m_state == 3) && (m_ph == 3);
    endfunction

    task automatic m_reset();
        m_state = 0; m_wr = 0; m_rd = 0; m_pc = 0; m_ph = 0;
        m_disp_prev = 0; m_done = 0; vs_d1 = 0; vs_d2 = 1;
    endtask

    // Advance the model by one clock using the inputs present in the current cycle.
    task automatic m_step();
        bit w, fs;
        int ns;
        w  = tb_win();
        fs = vs_d1 && !vs_d2;
        ns = m_state;
        m_done = 0;
        m_disp_prev = (m_state == 3) && w;
        case (m_state)
            0: if (store_req) ns = 1;
            1: begin
                if (release_req) ns = 0;
                else if (fs) begin ns = 2; m_wr = 0; end
            end
            2: begin
                if (release_req) ns = 0;
                else if (w) begin
                    if (m_wr == LAST) begin ns = 3; m_rd = 0; m_ph = 0; end
                    else m_wr++;
                end
            end
            default: begin
                if (release_req) begin ns = 0; m_ph = 0; end
                else if (store_req && m_ph == 0) ns = 1;
                else begin
                    if (fs) m_rd = 0;
                    else if (w && m_rd < LAST) m_rd++;
                    if (m_ph == 0) begin
                        if (pc_send_req) begin m_ph = 1; m_pc = 0; end
                    end else if (m_ph == 1) m_ph = 2;
                    else if (m_ph == 2) m_ph = 3;
                    else if (pc_ack) begin
                        if (m_pc == LAST) begin m_ph = 0; m_done = 1; end
                        else begin m_pc++; m_ph = 1; end
                    end
                end
            end
        endcase
        m_state = ns;
        vs_d2 = vs_d1;
        vs_d1 = vsync;
    endtask

    task automatic drive_vga();
        hcount = 11'(h);
        vcount = 10'(v);
        blank  = (h >= H_ACT) || (v >= V_ACT) || xb;
        vsync  = (v != 5);
    endtask

    // One clock: update model, take the edge, then present the next cycle's inputs.
    task automatic cycle();
        if (!reset_n) m_reset();
        else          m_step();
        @(posedge clk);
        #1;
        store_req = 0; release_req = 0; pc_send_req = 0; pc_ack = 0;
        h++;
        if (h == H_TOT) begin
            h = 0;
            v++;
            if (v == V_TOT) v = 0;
        end
        xb = rnd_blank && ($urandom_range(3) == 0);
        drive_vga();
        #1;
    endtask

    // Store and run until the model reports READING_FRAME.
    task automatic capture(output bit ok);
        ok = 0;
        store_req = 1;
        for (int i = 0; i < 800 && !ok; i++) begin
            cycle();
            if (m_state == 3) ok = 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        n_checks++; if (bram_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bram_state); end
        n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", bram_we); end
        n_checks++; if (bram_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bram_addr); end
        n_checks++; if (in_display_bram !== 1'b0) begin n_fail++; $display("FAIL rst_disp: got %0b want 0", in_display_bram); end
        n_checks++; if (pc_byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pcv: got %0b want 0", pc_byte_valid); end
        n_checks++; if (pc_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", pc_done); end
        reset_n = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin pc_send_req = 1; release_req = 1; end
            cycle();
            n_checks++; if (bram_state !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d want 0", bram_state); end
        end
    endtask

    task automatic test_capture();
        int  wcnt;
        bit  done;
        wcnt = 0; done = 0;
        rnd_blank = 1;
        store_req = 1;
        for (int i = 0; i < 600 && !done; i++) begin
            cycle();
            n_checks++; if (bram_state !== 2'(m_state)) begin n_fail++; $display("FAIL cap_state: got %0d want %0d", bram_state, m_state); end
            n_checks++; if (bram_we !== exp_we()) begin n_fail++; $display("FAIL cap_we: got %0b want %0b h=%0d v=%0d", bram_we, exp_we(), h, v); end
            if (bram_we === 1'b1) begin
                n_checks++; if (bram_addr !== AW'(wcnt)) begin n_fail++; $display("FAIL cap_addr: got %0d want %0d", bram_addr, wcnt); end
                wcnt++;
                if (wcnt == 32) begin
                    cycle();
                    n_checks++; if (bram_state !== 2'd3) begin n_fail++; $display("FAIL cap_to_read: got %0d want 3", bram_state); end
                    n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL cap_we_after: got %0b want 0", bram_we); end
                    done = 1;
                end
            end
        end
        n_checks++; if (!done || wcnt != 32) begin n_fail++; $display("FAIL cap_count: got %0d writes want 32 (done=%0b)", wcnt, done); end
        rnd_blank = 0;
    endtask

    task automatic test_display();
        bit seen00;
        seen00 = 0;
        for (int i = 0; i < 2 * H_TOT * V_TOT; i++) begin
            cycle();
            n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL disp_we: got %0b want 0", bram_we); end
            n_checks++; if (bram_addr !== AW'(exp_addr())) begin n_fail++; $display("FAIL disp_addr: got %0d want %0d", bram_addr, exp_addr()); end
            n_checks++; if (in_display_bram !== exp_disp()) begin n_fail++; $display("FAIL disp_valid: got %0b want %0b", in_display_bram, exp_disp()); end
            if (h == 0 && v == 0) begin
                seen00 = 1;
                n_checks++; if (bram_addr !== 5'd0) begin n_fail++; $display("FAIL disp_addr00: got %0d want 0", bram_addr); end
                n_checks++; if (in_display_bram !== 1'b0) begin n_fail++; $display("FAIL disp_valid00: got %0b want 0", in_display_bram); end
            end
            if (seen00 && h == 1 && v == 0) begin
                n_checks++; if (in_display_bram !== 1'b1) begin n_fail++; $display("FAIL disp_rise: got %0b want 1", in_display_bram); end
            end
            if (seen00 && h == 0 && v == 1) begin
                n_checks++; if (bram_addr !== 5'd8) begin n_fail++; $display("FAIL disp_addr01: got %0d want 8", bram_addr); end
            end
        end
    endtask

    task automatic test_pc_send();
        int nbytes, age, ndone;
        bit last_ack, fin;
        nbytes = 0; age = 0; ndone = 0; last_ack = 0; fin = 0;
        pc_send_req = 1;
        for (int i = 0; i < 1500 && !fin; i++) begin
            cycle();
            n_checks++; if (pc_byte_valid !== exp_pcv()) begin n_fail++; $display("FAIL pc_valid: got %0b want %0b", pc_byte_valid, exp_pcv()); end
            n_checks++; if (bram_addr !== AW'(exp_addr())) begin n_fail++; $display("FAIL pc_addr: got %0d want %0d", bram_addr, exp_addr()); end
            n_checks++; if (pc_done !== m_done) begin n_fail++; $display("FAIL pc_done_model: got %0b want %0b", pc_done, m_done); end
            if (pc_done === 1'b1) begin
                ndone++;
                n_checks++; if (!(nbytes == 32 && last_ack)) begin n_fail++; $display("FAIL pc_done_when: bytes %0d last_ack %0b want 32/1", nbytes, last_ack); end
                fin = 1;
            end else begin
                n_checks++; if (in_display_bram !== 1'b0) begin n_fail++; $display("FAIL pc_disp: got %0b want 0", in_display_bram); end
            end
            last_ack = 0;
            if (!fin) begin
                if (pc_byte_valid === 1'b1) begin
                    if (age == 3) begin
                        pc_ack = 1;
                        n_checks++; if (bram_addr !== AW'(nbytes)) begin n_fail++; $display("FAIL pc_byte_addr: got %0d want %0d", bram_addr, nbytes); end
                        nbytes++; age = 0; last_ack = 1;
                    end else age++;
                end else age = 0;
            end
        end
        repeat (6) begin
            cycle();
            n_checks++; if (pc_done !== 1'b0) begin n_fail++; $display("FAIL pc_done_pulse: got %0b want 0", pc_done); end
        end
        n_checks++; if (ndone != 1 || nbytes != 32) begin n_fail++; $display("FAIL pc_total: got %0d done %0d bytes, want 1 and 32", ndone, nbytes); end
    endtask

    task automatic test_pc_random();
        bit fin;
        fin = 0;
        pc_send_req = 1;
        for (int i = 0; i < 3000 && !fin; i++) begin
            cycle();
            n_checks++; if (pc_byte_valid !== exp_pcv()) begin n_fail++; $display("FAIL rnd_valid: got %0b want %0b", pc_byte_valid, exp_pcv()); end
            n_checks++; if (bram_addr !== AW'(exp_addr())) begin n_fail++; $display("FAIL rnd_addr: got %0d want %0d", bram_addr, exp_addr()); end
            n_checks++; if (in_display_bram !== exp_disp()) begin n_fail++; $display("FAIL rnd_disp: got %0b want %0b", in_display_bram, exp_disp()); end
            n_checks++; if (pc_done !== m_done) begin n_fail++; $display("FAIL rnd_done: got %0b want %0b", pc_done, m_done); end
            if (m_done) fin = 1;
            else begin
                pc_ack = ($urandom_range(2) == 0);
                if ($urandom_range(15) == 0) pc_send_req = 1;
            end
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL rnd_timeout: got no pc_done want one"); end
    endtask

    task automatic test_release_pc();
        bit fired;
        fired = 0;
        pc_send_req = 1;
        for (int i = 0; i < 1500 && !fired; i++) begin
            cycle();
            if (pc_byte_valid === 1'b1 && bram_addr == 5'd10) begin
                release_req = 1;
                fired = 1;
            end else if (pc_byte_valid === 1'b1) pc_ack = 1;
        end
        n_checks++; if (!fired) begin n_fail++; $display("FAIL rel_reach: got no byte 10 want it"); end
        cycle();
        n_checks++; if (bram_state !== 2'd0) begin n_fail++; $display("FAIL rel_state: got %0d want 0", bram_state); end
        n_checks++; if (pc_byte_valid !== 1'b0) begin n_fail++; $display("FAIL rel_pcv: got %0b want 0", pc_byte_valid); end
        repeat (10) begin
            cycle();
            n_checks++; if (pc_done !== 1'b0) begin n_fail++; $display("FAIL rel_done: got %0b want 0", pc_done); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, pulsed;
        int wcnt;
        capture(ok);
        n_checks++; if (!ok || bram_state !== 2'd3) begin n_fail++; $display("FAIL b2b_read: got %0d want 3", bram_state); end
        store_req = 1; release_req = 1;
        cycle();
        n_checks++; if (bram_state !== 2'd0) begin n_fail++; $display("FAIL b2b_relwins: got %0d want 0", bram_state); end
        store_req = 1;
        wcnt = 0; pulsed = 0;
        for (int i = 0; i < 800 && m_state != 3; i++) begin
            cycle();
            n_checks++; if (bram_state !== 2'(m_state)) begin n_fail++; $display("FAIL b2b_state: got %0d want %0d", bram_state, m_state); end
            n_checks++; if (bram_we !== exp_we()) begin n_fail++; $display("FAIL b2b_we: got %0b want %0b", bram_we, exp_we()); end
            if (bram_we === 1'b1) begin
                n_checks++; if (bram_addr !== AW'(wcnt)) begin n_fail++; $display("FAIL b2b_addr: got %0d want %0d", bram_addr, wcnt); end
                wcnt++;
            end
            if (m_state == 2 && !pulsed) begin store_req = 1; pc_send_req = 1; pulsed = 1; end
        end
        n_checks++; if (wcnt != 32 || bram_state !== 2'd3) begin n_fail++; $display("FAIL b2b_total: got %0d writes state %0d want 32 and 3", wcnt, bram_state); end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 0;
        store_req = 1;
        for (int i = 0; i < 800 && !found; i++) begin
            cycle();
            if (m_state == 2 && m_wr >= 5 && tb_win()) found = 1;
        end
        n_checks++; if (!found || bram_we !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got we %0b want 1", bram_we); end
        reset_n = 0;
        #1;
        n_checks++; if (bram_state !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", bram_state); end
        n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %0b want 0", bram_we); end
        n_checks++; if (bram_addr !== '0) begin n_fail++; $display("FAIL mid_addr: got %0d want 0", bram_addr); end
        repeat (3) cycle();
        reset_n = 1;
        repeat (5) begin
            cycle();
            n_checks++; if (bram_state !== 2'd0) begin n_fail++; $display("FAIL mid_idle: got %0d want 0", bram_state); end
        end
    endtask

    initial begin
        reset_n = 0; store_req = 0; release_req = 0; pc_send_req = 0; pc_ack = 0;
        h = 0; v = 0; rnd_blank = 0; xb = 0;
        drive_vga();
        m_reset();
        #2;
        test_reset();
        test_capture();
        test_display();
        test_pc_send();
        test_pc_random();
        test_release_pc();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
